key_event_counter: RTL and testbench

- Upstream source for the 16-bit `binary_input` of the seven-segment display controller on the DE2 board.
- Two raw active-low pushbuttons each pass through synchronisation and debouncing.
- Each button press produces exactly one increment or decrement of a decimal-range counter, 0..MAX_COUNT.
- The count is presented as a registered 16-bit unsigned binary value.

---
 rtl/key_event_counter.sv | 104 ++++++++++
 tb/tb_key_event_counter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_counter.sv
// Debounced up/down pushbutton counter feeding the DE2 seven-segment display.
// Define KEY_COUNTER_WRAP_EN to wrap at the limits instead of saturating.
module key_event_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned MAX_COUNT       = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_up_n,
    input  logic        key_down_n,
    input  logic        clear,
    output logic [15:0] binary_output,
    output logic        changed
);

    localparam logic [19:0] DCNT_LAST = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] CNT_MAX   = 16'(MAX_COUNT);

    // Index 0 is the up key, index 1 the down key.
    logic [1:0]  key_raw;
    logic [1:0]  s1_q, s1_d;
    logic [1:0]  s2_q, s2_d;
    logic [1:0]  db_q, db_d;
    logic [1:0]  db_dly_q, db_dly_d;
    logic [19:0] dcnt_q [2];
    logic [19:0] dcnt_d [2];
    logic [1:0]  press;
    logic [15:0] count_q, count_d;
    logic        changed_q, changed_d;

    assign key_raw = {key_down_n, key_up_n};

    always_comb begin
        s1_d     = key_raw;
        s2_d     = s1_q;
        db_d     = db_q;
        db_dly_d = db_q;
        for (int k = 0; k < 2; k++) begin
            dcnt_d[k] = '0;
            if (s2_q[k] != db_q[k]) begin
                if (dcnt_q[k] == DCNT_LAST) begin
                    db_d[k] = s2_q[k];
                end else begin
                    dcnt_d[k] = dcnt_q[k] + 20'd1;
                end
            end
        end
    end

    // Only the accepted falling edge (press) counts; releases are ignored.
    assign press = db_dly_q & ~db_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (press == 2'b01) begin
            if (count_q < CNT_MAX) begin
                count_d = count_q + 16'd1;
            end
`ifdef KEY_COUNTER_WRAP_EN
            else begin
                count_d = '0;
            end
`endif
        end else if (press == 2'b10) begin
            if (count_q != '0) begin
                count_d = count_q - 16'd1;
            end
`ifdef KEY_COUNTER_WRAP_EN
            else begin
                count_d = CNT_MAX;
            end
`endif
        end
        changed_d = (count_d != count_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '1;
            s2_q      <= '1;
            db_q      <= '1;
            db_dly_q  <= '1;
            dcnt_q[0] <= '0;
            dcnt_q[1] <= '0;
            count_q   <= '0;
            changed_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            db_q      <= db_d;
            db_dly_q  <= db_dly_d;
            dcnt_q[0] <= dcnt_d[0];
            dcnt_q[1] <= dcnt_d[1];
            count_q   <= count_d;
            changed_q <= changed_d;
        end
    end

    assign binary_output = count_q;
    assign changed       = changed_q;

endmodule

// File: tb/tb_key_event_counter.sv
// Bench for key_event_counter: directed scenarios plus random key activity,
// all checked against a window-based behavioural model of two DUT instances.
module tb_key_event_counter;

    localparam int D = 4;
`ifdef KEY_COUNTER_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        key_up_n;
    logic        key_down_n;
    logic        clear;
    logic [15:0] bo_main, bo_small;
    logic        chg_main, chg_small;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    key_event_counter #(.DEBOUNCE_CYCLES(D), .MAX_COUNT(9999)) dut_main (
        .clk(clk), .rst(rst), .key_up_n(key_up_n), .key_down_n(key_down_n),
        .clear(clear), .binary_output(bo_main), .changed(chg_main)
    );

    key_event_counter #(.DEBOUNCE_CYCLES(D), .MAX_COUNT(12)) dut_small (
        .clk(clk), .rst(rst), .key_up_n(key_up_n), .key_down_n(key_down_n),
        .clear(clear), .binary_output(bo_small), .changed(chg_small)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int max_of(input int i);
        return (i == 0) ? 9999 : 12;
    endfunction

    // Model: a key level is accepted once the synchronised samples (raw delayed
    // two edges) have disagreed with it for D consecutive edges.
    bit [D:0] hist [2];
    bit [1:0] acc, fell, raw, pr;
    int       m_cnt [2];
    bit [1:0] m_chg;
    int       nxt;
    bit       chk_en = 1'b0;

    always @(posedge clk) begin
        raw = {key_down_n, key_up_n};
        if (rst) begin
            hist[0] = '1;
            hist[1] = '1;
            acc     = 2'b11;
            fell    = 2'b00;
            m_cnt[0] = 0;
            m_cnt[1] = 0;
            m_chg    = 2'b00;
        end else begin
            pr = fell;
            for (int i = 0; i < 2; i++) begin
                nxt = m_cnt[i];
                if (clear) nxt = 0;
                else if (pr == 2'b01) nxt = (m_cnt[i] == max_of(i)) ? (WRAP ? 0 : m_cnt[i]) : m_cnt[i] + 1;
                else if (pr == 2'b10) nxt = (m_cnt[i] == 0) ? (WRAP ? max_of(i) : 0) : m_cnt[i] - 1;
                m_chg[i] = (nxt != m_cnt[i]);
                m_cnt[i] = nxt;
            end
            for (int k = 0; k < 2; k++) begin
                fell[k] = 1'b0;
                if (hist[k][D-1:0] == {D{~acc[k]}}) begin
                    acc[k]  = ~acc[k];
                    fell[k] = ~acc[k];
                end
                hist[k] = {raw[k], hist[k][D:1]};
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cnt_main", int'(bo_main), m_cnt[0]);
            chk("chg_main", int'(chg_main), int'(m_chg[0]));
            chk("cnt_small", int'(bo_small), m_cnt[1]);
            chk("chg_small", int'(chg_small), int'(m_chg[1]));
        end
    end

    int pc [2] = '{0, 0};
    always @(posedge clk) begin
        #1;
        if (chg_main)  pc[0]++;
        if (chg_small) pc[1]++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input bit up, input int lo, input int hi);
        if (up) key_up_n = 1'b0; else key_down_n = 1'b0;
        tick(lo);
        if (up) key_up_n = 1'b1; else key_down_n = 1'b1;
        tick(hi);
    endtask

    int c0, c1;

    initial begin
        rst = 1'b1; key_up_n = 1'b1; key_down_n = 1'b1; clear = 1'b0;
        tick(1);
        chk_en = 1'b1;
        tick(2);
        chk("rst_cnt", int'(bo_main), 0);
        chk("rst_chg", int'(chg_main), 0);
        rst = 1'b0;

        // clean press: update lands exactly six edges after the first low sample
        key_up_n = 1'b0;
        tick(6);
        chk("t1_pre", int'(bo_main), 0);
        tick(1);
        chk("t1_cnt", int'(bo_main), 1);
        chk("t1_chg", int'(chg_main), 1);
        tick(1);
        chk("t1_chg_off", int'(chg_main), 0);
        key_up_n = 1'b1;
        tick(10);
        chk("t1_release", int'(bo_main), 1);

        repeat (4) press_key(1'b1, 6, 6);
        chk("t2_start", int'(bo_main), 5);
        c0 = pc[0];
        repeat (5) begin
            key_down_n = 1'b0; tick(3);
            key_down_n = 1'b1; tick(1);
        end
        chk("t2_bounce", int'(bo_main), 5);
        chk("t2_bounce_pulses", pc[0] - c0, 0);
        key_down_n = 1'b0; tick(10);
        key_down_n = 1'b1; tick(8);
        chk("t2_hold", int'(bo_main), 4);
        chk("t2_hold_pulses", pc[0] - c0, 1);

        repeat (8) press_key(1'b1, 6, 6);
        chk("t3_small_at_max", int'(bo_small), 12);
        c1 = pc[1];
        press_key(1'b1, 6, 6);
        chk("t3_small_over", int'(bo_small), WRAP ? 0 : 12);
        chk("t3_small_pulses", pc[1] - c1, WRAP ? 1 : 0);

        clear = 1'b1; tick(1); clear = 1'b0;
        chk("t4_clear", int'(bo_main), 0);
        c0 = pc[0];
        press_key(1'b0, 6, 6);
        chk("t4_under", int'(bo_main), WRAP ? 9999 : 0);
        chk("t4_under_pulses", pc[0] - c0, WRAP ? 1 : 0);
        c0 = pc[0];
        press_key(1'b1, 6, 6);
        chk("t4_up_after", int'(bo_main), WRAP ? 0 : 1);
        chk("t4_up_pulses", pc[0] - c0, 1);

        clear = 1'b1; tick(1); clear = 1'b0;
        repeat (42) press_key(1'b1, 6, 6);
        chk("t5_start", int'(bo_main), 42);
        c0 = pc[0];
        key_up_n = 1'b0; key_down_n = 1'b0; tick(10);
        key_up_n = 1'b1; key_down_n = 1'b1; tick(8);
        chk("t5_both", int'(bo_main), 42);
        chk("t5_both_pulses", pc[0] - c0, 0);
        key_up_n = 1'b0;
        tick(6);
        clear = 1'b1;
        tick(1);
        chk("t5_clr_cnt", int'(bo_main), 0);
        chk("t5_clr_chg", int'(chg_main), 1);
        clear = 1'b0;
        key_up_n = 1'b1;
        tick(10);
        chk("t5_clr_hold", int'(bo_main), 0);

        press_key(1'b1, 6, 6);
        chk("t6_pre", int'(bo_main), 1);
        key_up_n = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(2);
        chk("t6_in_rst", int'(bo_main), 0);
        rst = 1'b0;
        tick(6);
        chk("t6_wait", int'(bo_main), 0);
        tick(1);
        chk("t6_cnt", int'(bo_main), 1);
        chk("t6_chg", int'(chg_main), 1);
        tick(20);
        chk("t6_held", int'(bo_main), 1);
        key_up_n = 1'b1;
        tick(10);

        // random activity: bounces, overlapping keys, clears and short resets
        repeat (2500) begin
            if ($urandom_range(0, 5) == 0) key_up_n = ~key_up_n;
            if ($urandom_range(0, 5) == 0) key_down_n = ~key_down_n;
            clear = ($urandom_range(0, 59) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        rst = 1'b0; clear = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
